// File: rtl/gcd_pkg.sv
// Shared types and sizing for the gcd4 sequencing controller.
package gcd_pkg;

    localparam int GCD_WIDTH   = 4;
    localparam int GCD_ITER_W  = GCD_WIDTH + 1;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_key_sync.sv
// KEY synchronizer and falling-edge detector; press_o is a one-cycle registered pulse.
module gcd_key_sync
    import gcd_pkg::*;
(
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n_i,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   key_s;

    assign key_s = sync_q[SYNC_STAGES-1];

    // Flops reset to the released level so leaving reset never looks like a press.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            press_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n_i};
            prev_q  <= key_s;
            press_o <= prev_q & ~key_s;
        end
    end

endmodule

// File: rtl/gcd_seq_ctrl.sv
// GCD by repeated subtraction with IDLE/CALC/DONE sequencing and registered outputs.
// Define GCD_KEY_SYNC_EN to treat start_i as a raw active-low KEY pin.
module gcd_seq_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH,
    parameter int ITER_W = WIDTH + 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start_i,
    input  logic              ack_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [ITER_W-1:0] iter_o
);

    gcd_state_e       state;
    logic [WIDTH-1:0] a_r, b_r;
    logic             start_evt;

`ifdef GCD_KEY_SYNC_EN
    gcd_key_sync u_key_sync (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n_i  (start_i),
        .press_o  (start_evt)
    );
`else
    assign start_evt = start_i;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            result_o <= '0;
            iter_o   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // Start takes priority over ack so a restart from DONE is never lost.
                    if (start_evt) begin
                        a_r    <= a_i;
                        b_r    <= b_i;
                        iter_o <= '0;
                        err_o  <= 1'b0;
                        if (a_i == '0 || b_i == '0) begin
                            result_o <= a_i | b_i;
                            err_o    <= ((a_i | b_i) == '0);
                            state    <= DONE;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end else begin
                            result_o <= '0;
                            state    <= CALC;
                            busy_o   <= 1'b1;
                            done_o   <= 1'b0;
                        end
                    end else if (state == DONE && ack_i) begin
                        state    <= IDLE;
                        done_o   <= 1'b0;
                        err_o    <= 1'b0;
                        result_o <= '0;
                        iter_o   <= '0;
                    end
                end
                CALC: begin
                    if (a_r == b_r) begin
                        result_o <= a_r;
                        state    <= DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        if (a_r > b_r) a_r <= a_r - b_r;
                        else           b_r <= b_r - a_r;
                        if (iter_o != {ITER_W{1'b1}}) iter_o <= iter_o + ITER_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Randomized self-checking bench for gcd_seq_ctrl against a Euclid-based reference model.
module tb_gcd_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int ITER_W = WIDTH + 1;

`ifdef GCD_KEY_SYNC_EN
    localparam int   LAT       = 3;
    localparam int   HOLD      = 10;
    localparam logic START_ON  = 1'b0;
    localparam logic START_OFF = 1'b1;
`else
    localparam int   LAT       = 0;
    localparam int   HOLD      = 1;
    localparam logic START_ON  = 1'b1;
    localparam logic START_OFF = 1'b0;
`endif

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N;
    logic              start_i;
    logic              ack_i;
    logic [WIDTH-1:0]  a_i, b_i;
    logic              busy_o, done_o, err_o;
    logic [WIDTH-1:0]  result_o;
    logic [ITER_W-1:0] iter_o;

    int n_chk = 0;
    int n_err = 0;

    gcd_seq_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start_i  (start_i),
        .ack_i    (ack_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .result_o (result_o),
        .iter_o   (iter_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Euclid by division: subtraction steps = sum of quotients minus one.
    function automatic void ref_gcd(input int a, input int b,
                                    output int g, output int steps, output int err);
        int x, y, r;
        err = (a == 0 && b == 0) ? 1 : 0;
        steps = 0;
        if (a == 0 || b == 0) begin
            g = a | b;
        end else begin
            x = a; y = b;
            while (y != 0) begin
                steps += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            steps -= 1;
        end
    endfunction

    // Starts one operation at a negedge and follows it to done_o.
    task automatic do_op(input int a, input int b, input int spam_at, input bit with_ack);
        int g, steps, err, exp_cyc, cyc, busy_cnt;
        bit seen;
        ref_gcd(a, b, g, steps, err);
        exp_cyc = LAT + 1 + ((a == 0 || b == 0) ? 0 : steps + 1);
        a_i = WIDTH'(a);
        b_i = WIDTH'(b);
        start_i = START_ON;
        if (with_ack) ack_i = 1'b1;
        cyc = 0; busy_cnt = 0; seen = 0;
        while (cyc < 100 && !seen) begin
            @(negedge CLOCK_50);
            cyc++;
            if (cyc == 1) ack_i = 1'b0;
            if (cyc == spam_at) start_i = START_ON;
            if (cyc == HOLD || cyc == spam_at + 1) start_i = START_OFF;
            if (cyc > LAT) begin
                a_i = WIDTH'($urandom);
                b_i = WIDTH'($urandom);
            end
            if (busy_o) busy_cnt++;
            if (done_o) seen = 1;
        end
        start_i = START_OFF;
        chk("done_seen", int'(seen), 1);
        chk("latency", cyc, exp_cyc);
        chk("busy_cycles", busy_cnt, exp_cyc - 1 - LAT);
        chk("result", int'(result_o), g);
        chk("iter", int'(iter_o), steps);
        chk("err", int'(err_o), err);
        chk("busy_in_done", int'(busy_o), 0);
    endtask

    task automatic do_ack(input int idle_cycles);
        int bad;
        ack_i = 1'b1;
        @(negedge CLOCK_50);
        ack_i = 1'b0;
        chk("ack_done", int'(done_o), 0);
        chk("ack_result", int'(result_o), 0);
        chk("ack_iter", int'(iter_o), 0);
        chk("ack_err", int'(err_o), 0);
        bad = 0;
        repeat (idle_cycles) begin
            @(negedge CLOCK_50);
            if (busy_o || done_o) bad++;
        end
        chk("idle_quiet", bad, 0);
    endtask

    task automatic reset_abort();
        int bad, cyc;
        a_i = 4'd15; b_i = 4'd1;
        start_i = START_ON;
        cyc = 0; bad = 0;
        while (cyc < 40) begin
            @(negedge CLOCK_50);
            cyc++;
            if (cyc == 4) start_i = START_OFF;
            if (cyc == 6) begin
                chk("pre_reset_busy", int'(busy_o), 1);
                RESET_N = 1'b0;
            end
            if (cyc == 9) RESET_N = 1'b1;
            if (cyc >= 7 && cyc <= 9)
                if (busy_o || done_o || err_o || result_o != 0 || iter_o != 0) bad++;
            if (cyc > 9 && (busy_o || done_o)) bad++;
        end
        chk("reset_abort", bad, 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        start_i = START_OFF;
        ack_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_result", int'(result_o), 0);
        chk("rst_iter", int'(iter_o), 0);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);

        reset_abort();

        do_op(12, 8, -1, 0);  do_ack(5);
        do_op(15, 1, -1, 0);  do_ack(5);
        do_op(7, 7, -1, 0);   do_ack(5);
        do_op(0, 9, -1, 0);   do_ack(5);
        do_op(0, 0, -1, 0);   do_ack(5);
        do_op(9, 0, -1, 0);   do_ack(5);
`ifndef GCD_KEY_SYNC_EN
        // Start pulse mid-CALC must be ignored.
        do_op(12, 8, 2, 0);
        // Start together with ack in DONE restarts.
        do_op(9, 6, -1, 1);
        do_ack(5);
`else
        do_op(12, 8, -1, 0);
        do_op(9, 6, -1, 0);
        do_ack(20);
`endif

        for (int i = 0; i < 24; i++) begin
            do_op($urandom_range(0, 15), $urandom_range(0, 15), -1, 0);
            if ($urandom_range(0, 2) != 0) do_ack(3);
        end
        do_ack(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_seq_ctrl.md
Name: gcd_seq_ctrl

Overview:
- Sequencing controller plus operand datapath for the gcd4 board design. It computes GCD(a,b) by repeated subtraction.
- Operands are sampled from board switches when a start request arrives, usually a KEY press.
- Exposes busy/done/result/iteration-count to the board top level, which drives LEDR/HEX from them.
- Instantiated once inside DE0_CV board top; clocked from CLOCK_50.

Parameters:
- WIDTH, 4, operand/result width in bits.
- ITER_W, WIDTH+1, width of the iteration counter.

Ports:
- CLOCK_50  input  1  sole clock.
- RESET_N  input  1  synchronous, active-low reset; sampled on rising CLOCK_50 edge.
- start_i  input  1  start request (format depends on GCD_KEY_SYNC_EN).
- ack_i  input  1  active-high; acknowledges result, returns controller to idle.
- a_i  input  WIDTH  operand A (e.g. SW[3:0]).
- b_i  input  WIDTH  operand B (e.g. SW[7:4]).
- busy_o  output  1  high while iterating.
- done_o  output  1  high while a valid result is held.
- err_o  output  1  high with done_o when both operands were zero.
- result_o  output  WIDTH  GCD result; valid while done_o=1.
- iter_o  output  ITER_W  number of subtraction steps taken; valid while done_o=1.

Behaviour:
- States: IDLE, CALC, DONE. All transitions occur on the rising CLOCK_50 edge.
- Reset (RESET_N=0 at an edge):
  - state=IDLE; internal regs a_r=b_r=0.
  - busy_o=0, done_o=0, err_o=0, result_o=0, iter_o=0.
  - Reset mid-CALC or in DONE aborts the operation; no result is produced.
- Start acceptance:
  - A start event is accepted only in IDLE or DONE; it is ignored in CALC.
  - On acceptance: a_r<=a_i, b_r<=b_i, iter<=0, err<=0.
  - If a_i==0 or b_i==0: result<=a_i|b_i, state<=DONE directly.
  - If both are zero, err<=1 in addition.
  - Otherwise state<=CALC.
- CALC, evaluated each cycle:
  - a_r==b_r: result<=a_r, state<=DONE.
  - a_r>b_r: a_r<=a_r-b_r, iter<=iter+1.
  - a_r<b_r: b_r<=b_r-a_r, iter<=iter+1.
  - Subtraction is unsigned, WIDTH bits, never underflows by construction.
  - iter saturates at all-ones (unreachable for nonzero operands; must still be safe).
- Latency:
  - With N subtraction steps, done_o rises N+1 edges after the edge that accepted start.
  - Zero-operand case: done_o rises at the accepting edge itself.
- Outputs are registered:
  - busy_o=(state==CALC), done_o=(state==DONE).
  - result_o and iter_o hold their values in DONE and are cleared to 0 on leaving DONE via ack_i.
  - err_o is cleared together with done_o.
- DONE exit:
  - ack_i=1 -> IDLE.
  - A start event in DONE restarts immediately; start wins over a simultaneous ack_i.
- ack_i in IDLE or CALC is ignored.
- a_i/b_i changes outside the acceptance edge have no effect.

Optional Feature:
- Macro GCD_KEY_SYNC_EN.
- Defined:
  - start_i is a raw active-low, asynchronous KEY pin.
  - It passes through a 2-flop synchronizer plus falling-edge detector.
  - A start event is the one-cycle pulse on the synchronized 1->0 transition; this adds 3 cycles of input latency.
  - Synchronizer flops reset to 1 (key released), so no spurious start after reset.
- Undefined:
  - start_i is a synchronous, active-high request.
  - A start event is any cycle with start_i=1 in IDLE/DONE; a held level restarts every time DONE is reached.

Decomposition:
- Shared package gcd_pkg:
  - state enum (IDLE, CALC, DONE), default WIDTH, derived ITER_W.
  - localparam for the synchronizer depth (2).
- One natural sub-module, gcd_key_sync (synchronizer + edge detector).
  - Instantiated only under GCD_KEY_SYNC_EN.
  - Ports CLOCK_50, RESET_N, key_n_i, press_o.

Test Plan (assertions below assume GCD_KEY_SYNC_EN undefined; bench must also run a variant with it defined):
- Reset: hold RESET_N=0 for 3 cycles during CALC of (15,1) -> all outputs 0 and state IDLE at next edge; no done_o pulse.
- a=12, b=8, start 1 cycle -> busy_o for 3 cycles, done_o after 3 edges, result_o=4, iter_o=2, err_o=0; ack_i -> IDLE, result_o=0.
- a=15, b=1 -> iter_o=14, result_o=1; a=7, b=7 -> done_o 1 edge after start, iter_o=0, result_o=7.
- Zero operands: (0,9) -> done_o at accept edge, result_o=9, err_o=0; (0,0) -> result_o=0, err_o=1.
- Ordering/handshake:
  - start pulses during CALC of (12,8) are ignored; result remains 4.
  - In DONE, start (a=9, b=6) with simultaneous ack_i -> restarts, result_o=3, iter_o=2.
- With GCD_KEY_SYNC_EN:
  - a 10-cycle-low KEY press yields exactly one computation.
  - done_o appears 3 cycles later than in the undefined build for identical operands.
